// File: rtl/safe_keypad_scanner_pkg.sv
// Shared types and constants for the safe keypad front end: key codes,
// scan states and the 2x3 matrix map.
package safe_keypad_scanner_pkg;

  localparam int NUM_ROWS = 2;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  // Snapshot bit index equals the key code: bit = row * NUM_COLS + col.
  typedef enum logic [2:0] {
    KEY_0     = 3'd0,
    KEY_1     = 3'd1,
    KEY_2     = 3'd2,
    KEY_3     = 3'd3,
    KEY_OK    = 3'd4,
    KEY_CLEAR = 3'd5
  } key_code_e;

  typedef enum logic {
    ROW0 = 1'b0,
    ROW1 = 1'b1
  } scan_state_e;

  // Row drives are active-low; exactly one row is pulled low at a time.
  localparam logic [NUM_ROWS-1:0] ROW0_DRIVE = 2'b10;
  localparam logic [NUM_ROWS-1:0] ROW1_DRIVE = 2'b01;

  function automatic logic is_single_key(input logic [NUM_KEYS-1:0] keys);
    return $onehot(keys);
  endfunction

  function automatic key_code_e key_from_bits(input logic [NUM_KEYS-1:0] keys);
    key_code_e code;
    code = KEY_0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) code = key_code_e'(3'(i));
    end
    return code;
  endfunction

endpackage

// File: rtl/safe_debounce_level.sv
// Two-flop synchroniser followed by a level debouncer: the output follows
// the input only after COUNT consecutive cycles of disagreement.
module safe_debounce_level #(
  parameter int COUNT = 1000
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o
);

  localparam int CNT_W = $clog2(COUNT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign q_o = r_level;

endmodule

// File: rtl/safe_keypad_scanner.sv
// Keypad matrix scanner and door-seal debouncer feeding the safe controller.
// Emits one single-cycle strobe per clean, isolated key press.
//
// state | meaning
// ROW0  | row 0 driven low, columns sampled into snapshot[2:0] at divider end
// ROW1  | row 1 driven low, columns complete the frame at divider end
module safe_keypad_scanner
  import safe_keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int DOOR_DEBOUNCE  = 1000
) (
  input  logic                clk_i,
  input  logic                arst_i,
  output logic [NUM_ROWS-1:0] row_o,
  input  logic [NUM_COLS-1:0] col_i,
  input  logic                door_raw_i,
  output logic                key_0_o,
  output logic                key_1_o,
  output logic                key_2_o,
  output logic                key_3_o,
  output logic                key_ok_o,
  output logic                key_clear_o,
  output logic                key_valid_o,
  output logic [2:0]          key_code_o,
  output logic                door_sealed_o
);

  localparam int DIV_W = $clog2(SCAN_DIV) + 1;
  localparam int STB_W = $clog2(DEBOUNCE_SCANS) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

  scan_state_e         r_state;
  logic [DIV_W-1:0]    r_div;
  logic [NUM_ROWS-1:0] r_row;
  logic [NUM_COLS-1:0] r_col_meta;
  logic [NUM_COLS-1:0] r_col_sync;
  logic [NUM_COLS-1:0] r_row0_snap;
  logic [NUM_KEYS-1:0] r_prev_frame;
  logic [STB_W-1:0]    r_stable_cnt;
  logic [NUM_KEYS-1:0] r_deb;
  logic [NUM_KEYS-1:0] r_pulse;
  logic                r_valid;
  logic [2:0]          r_code;

  logic                w_sample;
  logic                w_frame_end;
  logic [NUM_KEYS-1:0] w_frame;
  logic                w_same;
  logic [STB_W-1:0]    w_stable_next;
  logic                w_accept;
  logic                w_press;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_col_meta <= '0;
      r_col_sync <= '0;
    end else begin
      r_col_meta <= col_i;
      r_col_sync <= r_col_meta;
    end
  end

  assign w_sample    = (r_div == DIV_LAST);
  assign w_frame_end = w_sample && (r_state == ROW1);
  // Row 1 columns land in the upper half so bit index equals key code.
  assign w_frame     = {~r_col_sync, r_row0_snap};

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state     <= ROW0;
      r_div       <= '0;
      r_row       <= ROW0_DRIVE;
      r_row0_snap <= '0;
    end else if (w_sample) begin
      r_div <= '0;
      case (r_state)
        ROW0: begin
          r_row0_snap <= ~r_col_sync;
          r_state     <= ROW1;
          r_row       <= ROW1_DRIVE;
        end
        ROW1: begin
          r_state <= ROW0;
          r_row   <= ROW0_DRIVE;
        end
      endcase
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_same        = (w_frame == r_prev_frame);
  assign w_stable_next = !w_same                       ? '0      :
                         (r_stable_cnt == STB_MAX)     ? STB_MAX :
                                                         r_stable_cnt + 1'b1;
  assign w_accept      = (w_stable_next == STB_MAX);
  // A press counts only when leaving the all-released state with one key down.
  assign w_press       = w_frame_end && w_accept && (r_deb == '0) && is_single_key(w_frame);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_prev_frame <= '0;
      r_stable_cnt <= '0;
      r_deb        <= '0;
      r_pulse      <= '0;
      r_valid      <= 1'b0;
      r_code       <= '0;
    end else begin
      r_pulse <= '0;
      r_valid <= 1'b0;
      if (w_frame_end) begin
        r_prev_frame <= w_frame;
        r_stable_cnt <= w_stable_next;
        if (w_accept) r_deb <= w_frame;
        if (w_press) begin
          r_pulse <= w_frame;
          r_valid <= 1'b1;
          r_code  <= key_from_bits(w_frame);
        end
      end
    end
  end

  safe_debounce_level #(
    .COUNT(DOOR_DEBOUNCE)
  ) u_door_debounce (
    .clk_i (clk_i),
    .arst_i(arst_i),
    .d_i   (door_raw_i),
    .q_o   (door_sealed_o)
  );

  assign row_o       = r_row;
  assign key_0_o     = r_pulse[KEY_0];
  assign key_1_o     = r_pulse[KEY_1];
  assign key_2_o     = r_pulse[KEY_2];
  assign key_3_o     = r_pulse[KEY_3];
  assign key_ok_o    = r_pulse[KEY_OK];
  assign key_clear_o = r_pulse[KEY_CLEAR];
  assign key_valid_o = r_valid;
  assign key_code_o  = r_code;

endmodule

// File: tb/tb_safe_keypad_scanner.sv
// Bench for safe_keypad_scanner: a frame-level key reference model and a
// cycle-history door model, checked on every falling edge.
module tb_safe_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int DOOR     = 8;
  localparam int FRAME    = 2 * SCAN_DIV;

  logic       clk_i = 1'b0;
  logic       arst_i = 1'b0;
  logic [1:0] row_o;
  logic [2:0] col_i;
  logic       door_raw_i = 1'b0;
  logic       key_0_o, key_1_o, key_2_o, key_3_o, key_ok_o, key_clear_o;
  logic       key_valid_o;
  logic [2:0] key_code_o;
  logic       door_sealed_o;

  logic [5:0] pressed = '0;

  int         n_vec = 0;
  int         n_bad = 0;
  int         m = 0;

  logic [5:0] frame_hist[$];
  logic [5:0] deb_model;
  int         exp_m;
  logic [2:0] exp_code;
  logic [2:0] last_code;
  int         pulse_cnt[6];
  int         last_pulse_m;

  logic       door_hist[$];
  logic       door_plan[$];
  logic       door_lvl;
  logic       last_sealed;
  int         m_raw_edge;
  bit         dir_door = 1'b0;
  bit         rand_door = 1'b0;

  safe_keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .DOOR_DEBOUNCE (DOOR)
  ) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .row_o        (row_o),
    .col_i        (col_i),
    .door_raw_i   (door_raw_i),
    .key_0_o      (key_0_o),
    .key_1_o      (key_1_o),
    .key_2_o      (key_2_o),
    .key_3_o      (key_3_o),
    .key_ok_o     (key_ok_o),
    .key_clear_o  (key_clear_o),
    .key_valid_o  (key_valid_o),
    .key_code_o   (key_code_o),
    .door_sealed_o(door_sealed_o)
  );

  always #5 clk_i = ~clk_i;

  // Physical matrix: a column reads low when a pressed key sits on the driven row.
  assign col_i = ~((pressed[2:0] & {3{~row_o[0]}}) | (pressed[5:3] & {3{~row_o[1]}}));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m);
    end
  endtask

  function automatic logic door_at(input int i);
    return (i < 0) ? 1'b0 : door_hist[i];
  endfunction

  function automatic int total_pulses();
    int s = 0;
    for (int i = 0; i < 6; i++) s += pulse_cnt[i];
    return s;
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < 6; i++) pulse_cnt[i] = 0;
    last_pulse_m = 1 << 30;
  endtask

  task automatic tick();
    logic [5:0] got_p;
    logic [5:0] exp_p;
    bit         flip;
    logic       nxt;
    @(negedge clk_i);
    m++;
    check("row_o", row_o, ((m % FRAME) < SCAN_DIV) ? 32'h2 : 32'h1);
    exp_p = '0;
    if (m == exp_m) begin
      exp_p[exp_code] = 1'b1;
      last_code = exp_code;
    end
    got_p = {key_clear_o, key_ok_o, key_3_o, key_2_o, key_1_o, key_0_o};
    check("key_pulses", got_p, exp_p);
    check("key_valid", key_valid_o, exp_p != '0);
    check("key_code", key_code_o, last_code);
    for (int i = 0; i < 6; i++) if (got_p[i]) pulse_cnt[i]++;
    if (got_p != '0) last_pulse_m = m;
    // Door flips once the synchronised input has disagreed for DOOR cycles.
    flip = 1'b1;
    for (int j = 3; j <= DOOR + 2; j++) if (door_at(m - j) == door_lvl) flip = 1'b0;
    if (flip) door_lvl = ~door_lvl;
    check("door_sealed", door_sealed_o, door_lvl);
    if (door_sealed_o != last_sealed) begin
      if (dir_door) check("door_latency", m - m_raw_edge, DOOR + 2);
      last_sealed = door_sealed_o;
    end
    nxt = door_raw_i;
    if (door_plan.size() > 0) nxt = door_plan.pop_front();
    else if (rand_door && $urandom_range(0, 9) == 0) nxt = ~nxt;
    if (nxt != door_raw_i) m_raw_edge = m;
    door_raw_i = nxt;
    door_hist.push_back(nxt);
  endtask

  task automatic run_frame(input logic [5:0] keys);
    bit stable;
    int idx;
    pressed = keys;
    frame_hist.push_back(keys);
    stable = (frame_hist.size() >= DEB + 1);
    if (stable)
      for (int k = 1; k <= DEB; k++)
        if (frame_hist[frame_hist.size() - 1 - k] != keys) stable = 1'b0;
    if (stable) begin
      if (deb_model == '0 && $countones(keys) == 1) begin
        idx = 0;
        for (int i = 0; i < 6; i++) if (keys[i]) idx = i;
        exp_m    = m + FRAME;
        exp_code = 3'(idx);
      end
      deb_model = keys;
    end
    repeat (FRAME) tick();
  endtask

  task automatic apply_reset(input int hold);
    arst_i     = 1'b1;
    door_raw_i = 1'b0;
    #1;
    check("rst_row_o", row_o, 2'b10);
    check("rst_pulses", {key_clear_o, key_ok_o, key_3_o, key_2_o, key_1_o, key_0_o}, 0);
    check("rst_valid", key_valid_o, 0);
    check("rst_code", key_code_o, 0);
    check("rst_door", door_sealed_o, 0);
    repeat (hold) @(negedge clk_i);
    arst_i = 1'b0;
    m = 0;
    frame_hist.delete();
    frame_hist.push_back('0);
    deb_model = '0;
    exp_m     = -1;
    last_code = '0;
    door_hist.delete();
    door_hist.push_back(door_raw_i);
    door_lvl    = 1'b0;
    last_sealed = 1'b0;
    m_raw_edge  = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", m);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] keys;
    int         start_m;
    int         hold;
    int         r;

    #3;
    apply_reset(3);

    dir_door = 1'b1;
    for (int i = 0; i < 7; i++)  door_plan.push_back(1'b1);
    for (int i = 0; i < 12; i++) door_plan.push_back(1'b0);
    for (int i = 0; i < 20; i++) door_plan.push_back(1'b1);
    for (int i = 0; i < 20; i++) door_plan.push_back(1'b0);

    clear_counts();
    repeat (3) run_frame('0);
    check("idle_pulses", total_pulses(), 0);

    clear_counts();
    start_m = m;
    repeat (10) run_frame(6'b000100);
    check("key2_count", pulse_cnt[2], 1);
    check("key2_others", total_pulses() - pulse_cnt[2], 0);
    check("key2_in_4_frames", (last_pulse_m - start_m) <= 4 * FRAME, 1);
    check("key2_code", key_code_o, 2);
    repeat (3) run_frame('0);

    clear_counts();
    for (int i = 0; i < 6; i++) run_frame((i % 2 == 0) ? 6'b000010 : 6'b000000);
    repeat (3) run_frame('0);
    check("toggle_pulses", total_pulses(), 0);

    clear_counts();
    repeat (4) run_frame(6'b010001);
    repeat (4) run_frame(6'b000001);
    repeat (4) run_frame(6'b000000);
    check("multi_no_pulse", total_pulses(), 0);
    repeat (4) run_frame(6'b010000);
    check("ok_count", pulse_cnt[4], 1);
    check("ok_total", total_pulses(), 1);
    check("ok_code", key_code_o, 4);

    dir_door  = 1'b0;
    rand_door = 1'b1;
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      keys = 6'b000001 << $urandom_range(0, 5);
      else if (r < 8) keys = '0;
      else            keys = 6'($urandom_range(0, 63));
      hold = $urandom_range(1, 4);
      repeat (hold) run_frame(keys);
    end

    rand_door = 1'b0;
    pressed = 6'b001000;
    repeat (5) tick();
    #2;
    apply_reset(2);
    clear_counts();
    repeat (5) run_frame(6'b001000);
    check("key3_count", pulse_cnt[3], 1);
    check("key3_total", total_pulses(), 1);
    check("key3_code", key_code_o, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
